// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: one-hot state encodings,
// default timing constants and a counter-width helper.
package song_sequencer_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_PAUSED  = 4'b0001;
    localparam logic [STATE_W-1:0] ST_PLAYING = 4'b0010;
    localparam logic [STATE_W-1:0] ST_FLUSH   = 4'b0100;
    localparam logic [STATE_W-1:0] ST_GAP     = 4'b1000;

    localparam int DEF_GAP_BEATS    = 48;
    localparam int DEF_FLUSH_CYCLES = 2;

    // Width able to hold 0..max_count; never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/song_sequencer_gap_timer.sv
// Beat-strobed gap counter. expire pulses in the cycle whose beat brings the
// count up to GAP_BEATS, so the owner can leave the gap on the next edge.
module gap_timer
    import song_sequencer_pkg::*;
#(
    parameter int GAP_BEATS = DEF_GAP_BEATS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic beat,
    output logic expire
);

    localparam int CW = cnt_width(GAP_BEATS);
    localparam logic [CW-1:0] TERM = CW'(GAP_BEATS);
    localparam logic [CW-1:0] LAST = CW'(GAP_BEATS - 1);

    logic [CW-1:0] count_q;

    // Saturates at TERM so a long stall in the gap can never wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && beat && (count_q != TERM)) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expire = enable && beat && (count_q == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Play/pause and song-change controller between the button front-end and the
// song reader / note players. All outputs decode directly from state.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int NUM_SONGS    = 4,
    parameter int SONG_W       = 2,
    parameter int GAP_BEATS    = DEF_GAP_BEATS,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter bit LOOP         = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic              beat,
    input  logic              song_done,
    output logic              play,
    output logic [SONG_W-1:0] song,
    output logic              reset_player,
    output logic              in_gap
);

    localparam int FLUSH_W = cnt_width(FLUSH_CYCLES);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [SONG_W-1:0]  SONG_LAST  = SONG_W'(NUM_SONGS - 1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] resume_q;
    logic [STATE_W-1:0] resume_d;
    logic [SONG_W-1:0]  song_q;
    logic [SONG_W-1:0]  song_d;
    logic [SONG_W-1:0]  song_inc;
    logic [SONG_W-1:0]  song_dec;
    logic [SONG_W-1:0]  skip_song;
    logic [FLUSH_W-1:0] flush_q;
    logic               song_done_q;
    logic               done_evt;
    logic               skip;
    logic               gap_expire;

    assign song_inc  = (song_q == SONG_LAST) ? '0 : song_q + SONG_W'(1);
    assign song_dec  = (song_q == '0) ? SONG_LAST : song_q - SONG_W'(1);
    assign skip      = next_button || prev_button;
    assign skip_song = next_button ? song_inc : song_dec;
    assign done_evt  = song_done && !song_done_q;

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        song_d   = song_q;
        case (state_q)
            ST_PAUSED: begin
                if (skip) begin
                    song_d   = skip_song;
                    state_d  = ST_FLUSH;
                    resume_d = ST_PAUSED;
                end else if (play_button) begin
                    state_d = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                if (skip) begin
                    song_d   = skip_song;
                    state_d  = ST_FLUSH;
                    resume_d = ST_PLAYING;
                end else if (play_button) begin
                    state_d = ST_PAUSED;
                end else if (done_evt) begin
                    // Auto-advance; without LOOP the last song parks at song 0.
                    song_d   = song_inc;
                    state_d  = ST_FLUSH;
                    resume_d = (song_q == SONG_LAST && !LOOP) ? ST_PAUSED : ST_GAP;
                end
            end
            ST_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = (resume_q == ST_GAP && GAP_BEATS == 0) ? ST_PLAYING : resume_q;
                end
            end
            ST_GAP: begin
                if (skip) begin
                    song_d   = skip_song;
                    state_d  = ST_FLUSH;
                    resume_d = ST_PLAYING;
                end else if (play_button) begin
                    state_d = ST_PAUSED;
                end else if (gap_expire) begin
                    state_d = ST_PLAYING;
                end
            end
            default: state_d = ST_PAUSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_PAUSED;
            resume_q    <= ST_PAUSED;
            song_q      <= '0;
            flush_q     <= '0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            song_q      <= song_d;
            song_done_q <= song_done;
            flush_q     <= (state_q == ST_FLUSH && state_d == ST_FLUSH) ?
                           flush_q + FLUSH_W'(1) : '0;
        end
    end

    gap_timer #(
        .GAP_BEATS(GAP_BEATS)
    ) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state_q != ST_GAP),
        .enable(state_q == ST_GAP),
        .beat  (beat),
        .expire(gap_expire)
    );

    assign play         = (state_q == ST_PLAYING);
    assign reset_player = (state_q == ST_FLUSH);
    assign in_gap       = (state_q == ST_GAP);
    assign song         = song_q;

endmodule
